risc32_mem_responder: RTL and testbench

// Memory-side responder for the risc32 pipeline's word-addressed memory.

---
 rtl/risc32_mem_responder_if.sv | 26 ++
 rtl/risc32_mem_responder.sv | 133 +++++++++++++
 tb/tb_risc32_mem_responder.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/risc32_mem_responder_if.sv
// Request/acknowledge bus between the risc32 pipeline and its word memory:
// one read-only fetch port and one load/store data port.
interface risc32_mem_responder_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata,
    input  if_ack, if_rdata, if_err, d_ack, d_rdata, d_err
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata,
    output if_ack, if_rdata, if_err, d_ack, d_rdata, d_err
  );
endinterface

// File: rtl/risc32_mem_responder.sv
// Word memory serving fetch and data ports with round-robin arbitration and
// a configurable number of wait states between accept and acknowledge.
module risc32_mem_responder #(
  parameter int DEPTH       = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk1,
  input  logic                  rst,
  risc32_mem_responder_if.slave bus,
  output logic                  busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
  typedef enum logic {P_FETCH = 1'b0, P_DATA = 1'b1} port_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  port_e       last_q, last_d;
  port_e       port_q, port_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;

  logic        if_ack_q, if_ack_d, if_err_q, if_err_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        d_ack_q, d_ack_d, d_err_q, d_err_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  port_e       grant;
  logic        enter_resp;
  logic        in_range;
  logic        mem_we;
  logic [31:0] rd_word;
  logic [31:0] mem_q [DEPTH];

  always_comb begin
    // NOTE: every always_comb target gets a default first so no latch is inferred.
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    port_d   = port_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    grant    = P_FETCH;

    if (bus.if_req && bus.d_req) grant = (last_q == P_FETCH) ? P_DATA : P_FETCH;
    else if (bus.d_req)          grant = P_DATA;

    unique case (state_q)
      S_IDLE: begin
        if (bus.if_req || bus.d_req) begin
          port_d  = grant;
          last_d  = grant;
          addr_d  = (grant == P_DATA) ? bus.d_addr : bus.if_addr;
          we_d    = (grant == P_DATA) && bus.d_we;
          wdata_d = bus.d_wdata;
          cnt_d   = '0;
          state_d = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'(WAIT_STATES - 1)) state_d = S_RESP;
        else                              cnt_d   = cnt_q + 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // The access happens on the edge that enters RESP, using the values being
    // latched that same edge when there are no wait states.
    enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
    in_range   = addr_d < 32'(DEPTH);
    rd_word    = mem_q[addr_d[AW-1:0]];
    mem_we     = enter_resp && we_d && in_range && !rst;

    if_ack_d   = enter_resp && (port_d == P_FETCH);
    if_err_d   = if_ack_d && !in_range;
    if_rdata_d = (if_ack_d && in_range) ? rd_word : '0;
    d_ack_d    = enter_resp && (port_d == P_DATA);
    d_err_d    = d_ack_d && !in_range;
    d_rdata_d  = (d_ack_d && in_range && !we_d) ? rd_word : '0;
  end

  always_ff @(posedge clk1) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      last_q     <= P_FETCH;
      port_q     <= P_FETCH;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_ack_q   <= 1'b0;
      if_err_q   <= 1'b0;
      if_rdata_q <= '0;
      d_ack_q    <= 1'b0;
      d_err_q    <= 1'b0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      port_q     <= port_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_ack_q   <= if_ack_d;
      if_err_q   <= if_err_d;
      if_rdata_q <= if_rdata_d;
      d_ack_q    <= d_ack_d;
      d_err_q    <= d_err_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // NOTE: the storage array has no reset; its contents survive rst by design.
  always_ff @(posedge clk1) begin
    if (mem_we) mem_q[addr_d[AW-1:0]] <= wdata_d;
  end

  assign bus.if_ack   = if_ack_q;
  assign bus.if_err   = if_err_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.d_ack    = d_ack_q;
  assign bus.d_err    = d_err_q;
  assign bus.d_rdata  = d_rdata_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_risc32_mem_responder.sv
// Directed bench for risc32_mem_responder: three instances (2, 3 and 0 wait
// states) share one set of stimulus signals selected by sel.
module tb_risc32_mem_responder;

  logic        clk1 = 1'b0;
  logic        rst  = 1'b1;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  int          sel = 0;
  int          cur_ws = 2;
  int          cyc = 0;
  int          ack_cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  logic        o_if_ack, o_if_err, o_d_ack, o_d_err, o_busy;
  logic [31:0] o_if_rdata, o_d_rdata;
  logic        busy_ws2, busy_ws3, busy_ws0;

  risc32_mem_responder_if bus_ws2 ();
  risc32_mem_responder_if bus_ws3 ();
  risc32_mem_responder_if bus_ws0 ();

  assign bus_ws2.if_req  = if_req && (sel == 0);
  assign bus_ws2.d_req   = d_req  && (sel == 0);
  assign bus_ws2.if_addr = if_addr;
  assign bus_ws2.d_we    = d_we;
  assign bus_ws2.d_addr  = d_addr;
  assign bus_ws2.d_wdata = d_wdata;
  assign bus_ws3.if_req  = if_req && (sel == 1);
  assign bus_ws3.d_req   = d_req  && (sel == 1);
  assign bus_ws3.if_addr = if_addr;
  assign bus_ws3.d_we    = d_we;
  assign bus_ws3.d_addr  = d_addr;
  assign bus_ws3.d_wdata = d_wdata;
  assign bus_ws0.if_req  = if_req && (sel == 2);
  assign bus_ws0.d_req   = d_req  && (sel == 2);
  assign bus_ws0.if_addr = if_addr;
  assign bus_ws0.d_we    = d_we;
  assign bus_ws0.d_addr  = d_addr;
  assign bus_ws0.d_wdata = d_wdata;

  risc32_mem_responder #(.DEPTH(32), .WAIT_STATES(2)) u_ws2 (
    .clk1(clk1), .rst(rst), .bus(bus_ws2), .busy(busy_ws2));
  risc32_mem_responder #(.DEPTH(32), .WAIT_STATES(3)) u_ws3 (
    .clk1(clk1), .rst(rst), .bus(bus_ws3), .busy(busy_ws3));
  risc32_mem_responder #(.DEPTH(32), .WAIT_STATES(0)) u_ws0 (
    .clk1(clk1), .rst(rst), .bus(bus_ws0), .busy(busy_ws0));

  always_comb begin
    case (sel)
      0: begin
        o_if_ack = bus_ws2.if_ack; o_if_err = bus_ws2.if_err; o_if_rdata = bus_ws2.if_rdata;
        o_d_ack  = bus_ws2.d_ack;  o_d_err  = bus_ws2.d_err;  o_d_rdata  = bus_ws2.d_rdata;
        o_busy   = busy_ws2;
      end
      1: begin
        o_if_ack = bus_ws3.if_ack; o_if_err = bus_ws3.if_err; o_if_rdata = bus_ws3.if_rdata;
        o_d_ack  = bus_ws3.d_ack;  o_d_err  = bus_ws3.d_err;  o_d_rdata  = bus_ws3.d_rdata;
        o_busy   = busy_ws3;
      end
      default: begin
        o_if_ack = bus_ws0.if_ack; o_if_err = bus_ws0.if_err; o_if_rdata = bus_ws0.if_rdata;
        o_d_ack  = bus_ws0.d_ack;  o_d_err  = bus_ws0.d_err;  o_d_rdata  = bus_ws0.d_rdata;
        o_busy   = busy_ws0;
      end
    endcase
  end

  always #5 clk1 = ~clk1;
  always @(posedge clk1) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drop_all();
    if_req = 1'b0;
    d_req  = 1'b0;
    d_we   = 1'b0;
  endtask

  task automatic select(input int s, input int ws);
    sel    = s;
    cur_ws = ws;
    #1;
  endtask

  // Counts edges from the request being presented until an ack is seen.
  task automatic wait_ack(output int edges, output bit got);
    edges = 0;
    got   = 1'b0;
    while (!got && edges < 40) begin
      @(posedge clk1);
      edges++;
      @(negedge clk1);
      if (o_if_ack || o_d_ack) got = 1'b1;
    end
  endtask

  // Called shortly after a posedge with the DUT idle; returns likewise.
  task automatic xfer(input bit is_data, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input bit keep, input bit exp_err,
                      input logic [31:0] exp_rd, input string tag);
    int edges;
    bit got;
    if (is_data) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    wait_ack(edges, got);
    check({tag, "_ack"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, "_lat"},   32'(edges), 32'(cur_ws + 1));
      check({tag, "_other"}, 32'(is_data ? o_if_ack : o_d_ack), 32'd0);
      check({tag, "_rdata"}, is_data ? o_d_rdata : o_if_rdata, exp_rd);
      check({tag, "_err"},   32'(is_data ? o_d_err : o_if_err), 32'(exp_err));
      check({tag, "_busy"},  32'(o_busy), 32'd1);
      ack_cyc = cyc;
    end
    @(posedge clk1); #1;
    check({tag, "_pulse"}, 32'(o_if_ack | o_d_ack), 32'd0);
    check({tag, "_idle"},  32'(o_busy), 32'd0);
    if (!keep || !got) drop_all();
  endtask

  task automatic tie(input bit exp_data, input logic [31:0] fa, input logic [31:0] exp_f,
                     input logic [31:0] da, input logic [31:0] exp_d, input string tag);
    int edges;
    bit got;
    if_req = 1'b1; if_addr = fa;
    d_req  = 1'b1; d_we = 1'b0; d_addr = da;
    wait_ack(edges, got);
    check({tag, "_ack"},   32'(got), 32'd1);
    check({tag, "_both"},  32'(o_if_ack & o_d_ack), 32'd0);
    check({tag, "_grant"}, 32'(o_d_ack), 32'(exp_data));
    check({tag, "_lat"},   32'(edges), 32'(cur_ws + 1));
    check({tag, "_rdata"}, exp_data ? o_d_rdata : o_if_rdata, exp_data ? exp_d : exp_f);
    @(posedge clk1); #1;
    if (!got) begin
      drop_all();
    end else if (exp_data) begin
      d_req = 1'b0;
      xfer(1'b0, 1'b0, fa, '0, 1'b0, 1'b0, exp_f, {tag, "_loser_f"});
    end else begin
      if_req = 1'b0;
      xfer(1'b1, 1'b0, da, '0, 1'b0, 1'b0, exp_d, {tag, "_loser_d"});
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk1); #1;
    rst = 1'b0;
  endtask

  initial begin
    int  prev;
    bit  seen;
    logic [31:0] ld_vals [4];

    repeat (2) @(posedge clk1);
    #1;
    rst = 1'b0;

    // Reset state of every instance
    for (int i = 0; i < 3; i++) begin
      select(i, 0);
      check("rst_acks",  32'({o_if_ack, o_d_ack, o_if_err, o_d_err}), 32'd0);
      check("rst_busy",  32'(o_busy), 32'd0);
      check("rst_rdata", o_if_rdata | o_d_rdata, 32'd0);
    end

    // Two wait states: fetch latency and store/load round trip
    select(0, 2);
    xfer(1'b1, 1'b1, 32'd3, 32'h2801_000A, 1'b0, 1'b0, 32'd0, "st3");
    xfer(1'b0, 1'b0, 32'd3, '0, 1'b0, 1'b0, 32'h2801_000A, "fetch3");
    xfer(1'b1, 1'b1, 32'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0, "st5");
    xfer(1'b1, 1'b0, 32'd5, '0, 1'b0, 1'b0, 32'hDEAD_BEEF, "ld5");

    // Out-of-range addresses: no write, no wrap onto low words
    xfer(1'b1, 1'b1, 32'd8,  32'h8888_8888, 1'b0, 1'b0, 32'd0, "st8");
    xfer(1'b1, 1'b1, 32'd31, 32'h3131_3131, 1'b0, 1'b0, 32'd0, "st31");
    xfer(1'b1, 1'b1, 32'd40, 32'h0BAD_F00D, 1'b0, 1'b1, 32'd0, "st40");
    xfer(1'b1, 1'b0, 32'd8,  '0, 1'b0, 1'b0, 32'h8888_8888, "ld8");
    xfer(1'b1, 1'b0, 32'd40, '0, 1'b0, 1'b1, 32'd0, "ld40");
    xfer(1'b1, 1'b0, 32'd32, '0, 1'b0, 1'b1, 32'd0, "ld32");
    xfer(1'b1, 1'b0, 32'd31, '0, 1'b0, 1'b0, 32'h3131_3131, "ld31");
    xfer(1'b1, 1'b1, 32'h8000_0005, 32'h5555_0000, 1'b0, 1'b1, 32'd0, "st_hi");
    xfer(1'b1, 1'b0, 32'd5, '0, 1'b0, 1'b0, 32'hDEAD_BEEF, "ld5_again");
    xfer(1'b0, 1'b0, 32'd40, '0, 1'b0, 1'b1, 32'd0, "fetch40");

    // Arbitration: data wins the first tie after reset
    do_reset();
    tie(1'b1, 32'd3, 32'h2801_000A, 32'd5, 32'hDEAD_BEEF, "tie1");
    xfer(1'b1, 1'b0, 32'd5, '0, 1'b0, 1'b0, 32'hDEAD_BEEF, "solo_d");
    tie(1'b0, 32'd3, 32'h2801_000A, 32'd5, 32'hDEAD_BEEF, "tie2");

    // Three wait states: reset in WAIT drops the store and its ack
    select(1, 3);
    xfer(1'b1, 1'b1, 32'd7, 32'hAAAA_5555, 1'b0, 1'b0, 32'd0, "st7");
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'd7; d_wdata = 32'h0000_1234;
    @(posedge clk1); #1;
    check("abort_busy_wait", 32'(o_busy), 32'd1);
    @(posedge clk1); #1;
    rst = 1'b1;
    @(posedge clk1); #1;
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_ack",  32'(o_d_ack), 32'd0);
    rst = 1'b0;
    drop_all();
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk1);
      if (o_d_ack || o_if_ack) seen = 1'b1;
    end
    check("abort_no_ack", 32'(seen), 32'd0);
    @(posedge clk1); #1;
    xfer(1'b1, 1'b0, 32'd7, '0, 1'b0, 1'b0, 32'hAAAA_5555, "ld7");

    // No wait states: back-to-back loads with req held high
    select(2, 0);
    ld_vals = '{32'h1000_0000, 32'h1000_0111, 32'h1000_0222, 32'h1000_0333};
    for (int i = 0; i < 4; i++)
      xfer(1'b1, 1'b1, 32'(i), ld_vals[i], 1'b0, 1'b0, 32'd0, "st_seq");
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      xfer(1'b1, 1'b0, 32'(i), '0, (i < 3), 1'b0, ld_vals[i], "ld_seq");
      if (i > 0) check("ld_seq_period", 32'(ack_cyc - prev), 32'd2);
      prev = ack_cyc;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
